// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-request sequencer in front of a synchronous single-port RAM
module mem_access_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INCR  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {IDLE, ISSUE, RWAIT, WB, RESP} state_t;

    state_t              state, next_state;
    logic [1:0]          op_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [2:0]          wait_cnt;

    assign req_ready = (state == IDLE);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = (req_op == OP_RSVD) ? RESP : ISSUE;
            ISSUE:   next_state = (op_r == OP_WRITE) ? RESP : RWAIT;
            RWAIT:   if (wait_cnt == '0) next_state = (op_r == OP_INCR) ? WB : RESP;
            WB:      next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_r        <= OP_READ;
            wdata_r     <= '0;
            wait_cnt    <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            op_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_r    <= req_op;
                        wdata_r <= req_wdata;
                        if (req_op == OP_RSVD) begin
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                        end else begin
                            ram_address <= req_addr;
                            ram_wren    <= (req_op == OP_WRITE);
                            if (req_op == OP_WRITE) ram_data <= req_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (op_r == OP_WRITE) begin
                        ram_wren  <= 1'b0;
                        rsp_rdata <= wdata_r;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else begin
                        wait_cnt <= 3'(READ_LAT - 1);
                    end
                end
                RWAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else if (op_r == OP_INCR) begin
                        // ram_data doubles as the holding register for the incremented value
                        ram_data <= ram_q + DATA_W'(1);
                        ram_wren <= 1'b1;
                    end else begin
                        rsp_rdata <= ram_q;
                        rsp_valid <= 1'b1;
                    end
                end
                WB: begin
                    ram_wren  <= 1'b0;
                    rsp_rdata <= ram_data;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Request/response sequencer that sits directly upstream of the single-port synchronous data RAM (address, clock, data, wren, q). It is the only driver of the RAM's address, data and wren inputs. It accepts one READ, WRITE or INCR (read-modify-write +1) request at a time from the processor core and returns one response per request through a valid/ready handshake. It hides the RAM read latency from the core.

Parameters:
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width
READ_LAT, 1, rising edges from the RAM sampling a read address until ram_q is valid for capture; legal values 1..4
CNT_W, 16, width of op_count

Ports:
clock  in  1  single system clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  2  00 READ, 01 WRITE, 10 INCR, 11 reserved
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data; used by WRITE only
rsp_valid  out  1  response present
rsp_ready  in  1  core accepts response
rsp_rdata  out  DATA_W  READ: ram_q; WRITE: echo of req_wdata; INCR: new value written; reserved: 0
rsp_err  out  1  1 only for reserved op
ram_address  out  ADDR_W  to RAM address
ram_data  out  DATA_W  to RAM data
ram_wren  out  1  to RAM wren
ram_q  in  DATA_W  from RAM q
op_count  out  CNT_W  completed response handshakes, wraps modulo 2^CNT_W

Behaviour:
- Reset: any edge with reset=1 forces IDLE.
  - ram_address=0, ram_data=0, ram_wren=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, op_count=0.
  - Takes priority over every other event, including one mid-operation. An in-flight op is abandoned: no response, and no later RAM write.
- All outputs are registered except req_ready, which is (state==IDLE).
- Accept: the edge with state==IDLE, reset=0, req_valid=1. Latch op, addr and wdata. Inputs are don't-care on other edges.
- FSM states: IDLE, ISSUE, RWAIT, WB, RESP.
- IDLE, on accept:
  - READ/INCR: ram_address<=addr, ram_wren<=0, go ISSUE.
  - WRITE: ram_address<=addr, ram_data<=wdata, ram_wren<=1, go ISSUE.
  - Reserved: rsp_rdata<=0, rsp_err<=1, rsp_valid<=1, go RESP. No RAM access.
- ISSUE (RAM samples at this edge):
  - WRITE: ram_wren<=0, rsp_rdata<=wdata, rsp_err<=0, rsp_valid<=1, go RESP.
  - READ/INCR: load wait counter with READ_LAT-1, go RWAIT.
- RWAIT:
  - Counter != 0: decrement.
  - Counter == 0, READ: capture ram_q into rsp_rdata, rsp_valid<=1, go RESP.
  - Counter == 0, INCR: ram_data<=ram_q+1 (mod 2^DATA_W, 0xFF->0x00), ram_wren<=1, hold the incremented value, go WB.
- WB: ram_wren<=0, rsp_rdata<=incremented value, rsp_valid<=1, go RESP.
- RESP:
  - Outputs are held stable while rsp_ready=0.
  - Edge with rsp_ready=1: rsp_valid<=0, rsp_err<=0, op_count+=1, go IDLE.
- Latency, accept edge to first edge with rsp_valid visible-high (READ_LAT=1): WRITE 1, READ 1+READ_LAT, INCR 2+READ_LAT, reserved 0 (rsp_valid high right after the accept edge).
- Throughput: no overlap. The next accept is no earlier than the edge after the response handshake.
- ram_wren is high for exactly one cycle per WRITE/INCR and never otherwise.
- ram_address is held from the accept until the next accept or reset.
- rsp_ready while rsp_valid=0 is ignored.

Test Plan:
- WRITE addr 0x26 data 0x33, rsp_ready=1, then READ 0x26 -> ram_wren high exactly 1 cycle; WRITE rsp_rdata=0x33 rsp_err=0; READ rsp_rdata=0x33 two edges after accept; op_count=2.
- Preload 0xFF at addr 0x10, INCR 0x10 -> rsp_rdata=0x00, RAM[0x10]=0x00, one ram_wren pulse; a second INCR -> rsp_rdata=0x01.
- READ with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held, req_ready=0, new req_valid ignored; response handshakes on the first edge with rsp_ready=1; op_count increments by 1 only.
- INCR at 0x40 (value 0x07), reset=1 on the edge entering WB -> ram_wren never high, RAM[0x40]=0x07, rsp_valid=0, all outputs at reset values, req_ready=1 next cycle.
- req_op=11 addr 0x05 -> rsp_valid high the cycle after accept, rsp_err=1, rsp_rdata=0x00, RAM untouched.
- READ_LAT=3, RAM model with 3-edge read latency, READ addr 0x26 holding 0xA5 -> rsp_valid first high 4 edges after accept, rsp_rdata=0xA5.
